// File: rtl/imm_decode_unit.sv
// RV32 immediate decoder with a one-entry registered output stage and a saturating illegal-opcode
// counter. Define IMM_DECODE_CSR_EN to decode SYSTEM (csr*i zimm) instead of flagging it illegal.
module imm_decode_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       imm_src,
  output logic [XLEN-1:0]  imm_ext,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpReg    = 7'b0110011;
`ifdef IMM_DECODE_CSR_EN
  localparam logic [6:0] OpSystem = 7'b1110011;
`endif

  logic [6:0]       op;
  logic [2:0]       src_d, src_q;
  logic [XLEN-1:0]  imm_d, imm_q;
  logic             ill_d, ill_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fire;

  assign op = instr[6:0];

  always_comb begin
    src_d = 3'b111;
    imm_d = '0;
    ill_d = 1'b0;
    unique case (op)
      OpLoad, OpAluImm, OpJalr: begin
        src_d = 3'b000;
        imm_d = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OpStore: begin
        src_d = 3'b001;
        imm_d = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OpBranch: begin
        src_d = 3'b010;
        imm_d = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OpJal: begin
        src_d = 3'b011;
        imm_d = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OpLui, OpAuipc: begin
        src_d = 3'b101;
        imm_d = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      end
      OpReg: begin
        src_d = 3'b111;
      end
`ifdef IMM_DECODE_CSR_EN
      OpSystem: begin
        // zimm lives in the rs1 field and is zero-extended
        src_d = 3'b110;
        imm_d = {{(XLEN-5){1'b0}}, instr[19:15]};
      end
`endif
      default: begin
        src_d = 3'b111;
        ill_d = 1'b1;
      end
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign fire     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      src_q   <= 3'b000;
      imm_q   <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (fire) begin
        valid_q <= 1'b1;
        src_q   <= src_d;
        imm_q   <= imm_d;
        ill_q   <= ill_d;
        if (ill_d && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_q;
  assign imm_src     = src_q;
  assign imm_ext     = imm_q;
  assign illegal     = ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_unit.sv
// Bench for imm_decode_unit: a 32-bit/8-bit-counter and a 64-bit/2-bit-counter instance share
// one random stimulus stream and are checked each cycle against an arithmetic reference model.
module tb_imm_decode_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [2:0]  a_imm_src;
  logic [31:0] a_imm_ext;
  logic [7:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [2:0]  b_imm_src;
  logic [63:0] b_imm_ext;
  logic [1:0]  b_cnt;

  imm_decode_unit #(.XLEN(32), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .instr(instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .imm_src(a_imm_src), .imm_ext(a_imm_ext),
    .illegal(a_illegal), .illegal_cnt(a_cnt)
  );

  imm_decode_unit #(.XLEN(64), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .imm_src(b_imm_src), .imm_ext(b_imm_ext),
    .illegal(b_illegal), .illegal_cnt(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  bit     m_valid;
  int     m_src;
  longint m_imm;
  bit     m_ill;
  int     m_cnt_a;
  int     m_cnt_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic longint sext(input longint val, input int n);
    if ((val >> (n - 1)) & 1) return val - (longint'(1) << n);
    return val;
  endfunction

  function automatic void ref_decode(input logic [31:0] w, output int src, output longint imm,
                                     output bit ill);
    src = 7;
    imm = 0;
    ill = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin src = 0; imm = sext(longint'(w[31:20]), 12); end
      7'h23: begin
        src = 1;
        imm = sext(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
      end
      7'h63: begin
        src = 2;
        imm = sext(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                   + longint'(w[11:8]) * 2, 13);
      end
      7'h6F: begin
        src = 3;
        imm = sext(longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * 4096
                   + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
      end
      7'h37, 7'h17: begin src = 5; imm = sext(longint'(w[31:12]) * 4096, 32); end
      7'h33: begin src = 7; end
`ifdef IMM_DECODE_CSR_EN
      7'h73: begin src = 6; imm = longint'(w[19:15]); end
`endif
      default: begin src = 7; ill = 1; end
    endcase
  endfunction

  always @(posedge clk) begin
    int     s;
    longint v;
    bit     il;
    bit     fire;
    fire = in_valid && (!m_valid || out_ready);
    if (reset) begin
      m_valid = 0; m_src = 0; m_imm = 0; m_ill = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (fire) begin
      ref_decode(instr, s, v, il);
      m_valid = 1; m_src = s; m_imm = v; m_ill = il;
      if (il) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic compare_all();
    logic [63:0] mi;
    logic        rdy;
    mi  = m_imm;
    rdy = !m_valid || out_ready;
    chk("a.in_ready", a_in_ready, rdy);
    chk("a.out_valid", a_out_valid, m_valid);
    chk("a.imm_src", a_imm_src, m_src[2:0]);
    chk("a.imm_ext", a_imm_ext, mi[31:0]);
    chk("a.illegal", a_illegal, m_ill);
    chk("a.illegal_cnt", a_cnt, m_cnt_a[7:0]);
    chk("b.in_ready", b_in_ready, rdy);
    chk("b.out_valid", b_out_valid, m_valid);
    chk("b.imm_src", b_imm_src, m_src[2:0]);
    chk("b.imm_ext", b_imm_ext, mi);
    chk("b.illegal", b_illegal, m_ill);
    chk("b.illegal_cnt", b_cnt, m_cnt_b[1:0]);
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33,
                           7'h73, 7'h7F, 7'h00};

  initial begin
    logic [31:0] r;
    logic [31:0] snap_imm;
    logic [2:0]  snap_src;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    step(); step();
    chk("rst.out_valid", a_out_valid, 0);
    chk("rst.imm_src", a_imm_src, 0);
    chk("rst.imm_ext", b_imm_ext, 0);
    chk("rst.illegal", a_illegal, 0);
    chk("rst.cnt", a_cnt, 0);
    reset = 1'b0;
    step();
    chk("post_rst.in_ready", a_in_ready, 1);

    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00812283;
    step();
    chk("lw.out_valid", a_out_valid, 1);
    chk("lw.imm_src", a_imm_src, 3'b000);
    chk("lw.imm_ext", a_imm_ext, 32'h00000008);

    instr = 32'hFE000EE3;
    step();
    chk("beq.imm_src", a_imm_src, 3'b010);
    chk("beq.imm_ext", a_imm_ext, 32'hFFFFFFFC);
    chk("beq.imm_ext64", b_imm_ext, 64'hFFFFFFFFFFFFFFFC);

    instr = 32'h123450B7;
    step();
    chk("lui.imm_src", a_imm_src, 3'b101);
    chk("lui.imm_ext", a_imm_ext, 32'h12345000);

    instr = 32'h34029073;
    step();
`ifdef IMM_DECODE_CSR_EN
    chk("csrrw.imm_src", a_imm_src, 3'b110);
    chk("csrrw.imm_ext", a_imm_ext, 32'h00000005);
    chk("csrrw.illegal", a_illegal, 0);
`else
    chk("csrrw.illegal", a_illegal, 1);
    chk("csrrw.imm_src", a_imm_src, 3'b111);
    chk("csrrw.imm_ext", a_imm_ext, 0);
`endif

    // Stall three cycles with a pending word, then release it
    snap_imm = a_imm_ext; snap_src = a_imm_src;
    out_ready = 1'b0; instr = 32'h00500093;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.in_ready", a_in_ready, 0);
      chk("stall.imm_ext", a_imm_ext, snap_imm);
      chk("stall.imm_src", a_imm_src, snap_src);
    end
    out_ready = 1'b1;
    step();
    chk("release.imm_ext", a_imm_ext, 32'h00000005);
    chk("release.out_valid", a_out_valid, 1);

    // Reset with a result held and a new word offered
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; instr = 32'h0000007F;
    step();
    chk("rst_busy.out_valid", a_out_valid, 0);
    chk("rst_busy.cnt", a_cnt, 0);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat.illegal", b_illegal, 1);
      chk("sat.imm_ext", b_imm_ext, 0);
      chk("sat.cnt_b", b_cnt, (i < 3) ? i + 1 : 3);
      chk("sat.cnt_a", a_cnt, i + 1);
    end

    // Idle drain: out_ready high with no accept empties the stage
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", a_out_valid, 0);
    chk("drain.cnt_a", a_cnt, 5);

    for (int i = 0; i < 3000; i++) begin
      r         = $urandom();
      instr     = {r[31:7], ops[$urandom_range(0, 11)]};
      if ($urandom_range(0, 7) == 0) instr = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
